// File: rtl/d_ff_pkg.sv
// ----------------------------------------------------------------------------
// d_ff_pkg
// Shared defaults for the d_ff register.
//   D_FF_WIDTH_DEFAULT : default data width of d/q
//   D_FF_RESET_FILL    : bit value replicated across the word for RESET_VAL
//   D_FF_PRESET_FILL   : bit value replicated across the word for PRESET_VAL
// ----------------------------------------------------------------------------
package d_ff_pkg;

  localparam int unsigned D_FF_WIDTH_DEFAULT = 1;

  // Reset/preset defaults are expressed as a fill bit so that they scale with
  // whatever WIDTH the instance picks.
  localparam logic D_FF_RESET_FILL  = 1'b0;
  localparam logic D_FF_PRESET_FILL = 1'b1;

endpackage : d_ff_pkg

// File: rtl/d_ff.sv
// ----------------------------------------------------------------------------
// d_ff
// WIDTH-bit rising-edge D register with asynchronous active-low reset and
// asynchronous active-low preset. Reset has priority over preset.
//
// Parameters
//   WIDTH      : data width (>= 1)
//   RESET_VAL  : value forced on q while reset is low
//   PRESET_VAL : value forced on q while preset is low (and reset is high)
//
// Ports (positional order: d, clk, preset, reset, q [, qn])
//   d      in  [WIDTH-1:0] data sampled on rising clk
//   clk    in              clock, rising edge active
//   preset in              asynchronous set, active low
//   reset  in              asynchronous reset, active low
//   q      out [WIDTH-1:0] registered data
//   qn     out [WIDTH-1:0] bitwise inverse of q (only with D_FF_QN_EN)
//
// Build options
//   D_FF_QN_EN : when defined, adds the qn output after q.
//
// Reset release is expected to be synchronous to clk; there is no internal
// synchronizer on reset or preset.
// ----------------------------------------------------------------------------
module d_ff
  import d_ff_pkg::*;
#(
  parameter int unsigned      WIDTH      = D_FF_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{D_FF_RESET_FILL}},
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{D_FF_PRESET_FILL}}
) (
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             preset,
  input  logic             reset,
  output logic [WIDTH-1:0] q
`ifdef D_FF_QN_EN
  ,
  output logic [WIDTH-1:0] qn
`endif
);

  if (WIDTH < 1) begin : g_width_chk
    $error("d_ff: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] q_q;

  // Reset is tested first so it wins when both controls are low. If reset is
  // released while preset is still low, no async event fires; the next clk
  // edge lands in the preset branch and loads PRESET_VAL.
  always_ff @(posedge clk or negedge reset or negedge preset) begin
    if (!reset) begin
      q_q <= RESET_VAL;
    end else if (!preset) begin
      q_q <= PRESET_VAL;
    end else begin
      q_q <= d;
    end
  end

  assign q = q_q;

`ifdef D_FF_QN_EN
  assign qn = ~q_q;
`endif

endmodule : d_ff

// File: tb/tb_d_ff.sv
module tb_d_ff;

  localparam int unsigned W = 4;
  localparam logic [W-1:0] RV = 4'h0;
  localparam logic [W-1:0] PV = 4'hF;

  logic [W-1:0] d;
  logic         clk;
  logic         preset;
  logic         reset;
  logic [W-1:0] q;
`ifdef D_FF_QN_EN
  logic [W-1:0] qn;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sb[$];

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] exp_q;
  } vec_t;

  vec_t vecs[12];

  d_ff #(.WIDTH(W)) dut (
    .d      (d),
    .clk    (clk),
    .preset (preset),
    .reset  (reset),
    .q      (q)
`ifdef D_FF_QN_EN
    ,
    .qn     (qn)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] exp);
    checks++;
    if (q !== exp) begin
      errors++;
      $display("FAIL %s: q=%h required %h (t=%0t)", name, q, exp, $time);
    end
`ifdef D_FF_QN_EN
    checks++;
    if (qn !== ~exp) begin
      errors++;
      $display("FAIL %s_qn: qn=%h required %h (t=%0t)", name, qn, ~exp, $time);
    end
`endif
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] exp_v;

    // q equals d one edge later, for a toggling/varied pattern
    vecs[0]  = '{4'hA, 4'hA};
    vecs[1]  = '{4'h5, 4'h5};
    vecs[2]  = '{4'hA, 4'hA};
    vecs[3]  = '{4'h5, 4'h5};
    vecs[4]  = '{4'hF, 4'hF};
    vecs[5]  = '{4'h0, 4'h0};
    vecs[6]  = '{4'h1, 4'h1};
    vecs[7]  = '{4'h2, 4'h2};
    vecs[8]  = '{4'h4, 4'h4};
    vecs[9]  = '{4'h8, 4'h8};
    vecs[10] = '{4'h3, 4'h3};
    vecs[11] = '{4'hC, 4'hC};

    d      = '0;
    preset = 1'b1;
    reset  = 1'b1;

    // async reset before any clock edge
    #1 reset = 1'b0;
    #1 check("reset_async_initial", RV);

    // clk edges ignored while reset is low
    d = 4'h9;
    edge_sample();
    check("reset_holds_over_clk", RV);

    // reset release: first edge loads d
    @(negedge clk);
    reset = 1'b1;
    d     = 4'hA;
    #1 check("reset_release_hold", RV);
    edge_sample();
    check("first_load_after_reset", 4'hA);

    // table-driven capture through the scoreboard
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      d = vecs[i].d;
      sb.push_back(vecs[i].exp_q);
      edge_sample();
      exp_v = sb.pop_front();
      check($sformatf("capture_%0d", i), exp_v);
      // d wiggles between edges; q must hold
      d = ~vecs[i].d;
      #2 check($sformatf("hold_%0d", i), exp_v);
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    // async reset mid-cycle with q all ones
    @(negedge clk);
    d = 4'hF;
    edge_sample();
    check("set_ones_before_reset", 4'hF);
    #2 reset = 1'b0;
    #0 #0;
    #1 check("reset_async_midcycle", RV);
    @(negedge clk);
    reset = 1'b1;
    d     = 4'h0;
    edge_sample();
    check("after_reset_zero", 4'h0);

    // async preset with q=0; clk edges with d=0 leave q at PRESET_VAL
    #2 preset = 1'b0;
    #1 check("preset_async", PV);
    d = 4'h0;
    edge_sample();
    check("preset_ignores_clk_1", PV);
    edge_sample();
    check("preset_ignores_clk_2", PV);

    // preset release with d=0: hold until next edge, then capture
    @(negedge clk);
    preset = 1'b1;
    d      = 4'h0;
    #1 check("preset_release_hold", PV);
    edge_sample();
    check("preset_release_capture", 4'h0);

    // simultaneous assertion: reset wins
    @(negedge clk);
    d = 4'h7;
    #1;
    reset  = 1'b0;
    preset = 1'b0;
    #1 check("both_low_reset_wins", RV);
    edge_sample();
    check("both_low_over_clk", RV);

    // reset released while preset still low: PRESET_VAL by next edge
    @(negedge clk);
    reset = 1'b1;
    edge_sample();
    check("reset_release_under_preset", PV);

    // reset asserted while preset held low pulls q back to RESET_VAL
    #1 reset = 1'b0;
    #1 check("reset_over_active_preset", RV);
    @(negedge clk);
    reset = 1'b1;
    edge_sample();
    check("preset_reloads", PV);

    // release preset and resume normal capture
    @(negedge clk);
    preset = 1'b1;
    d      = 4'h6;
    edge_sample();
    check("resume_capture", 4'h6);

    // qn scenario: 4'hA captured, then reset
    @(negedge clk);
    d = 4'hA;
    edge_sample();
    check("qn_capture_A", 4'hA);
    #1 reset = 1'b0;
    #1 check("qn_reset", RV);
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_d_ff
